sdr_port_sched: RTL and testbench

Port scheduler and refresh timer for the 16-bit SDR SDRAM controller FSM. Shares the single SDRAM command FSM between up to `nr_of_ports` requesting egress FIFOs with round-robin fairness. Generates periodic auto-refresh requests and drives the FSM's `refresh_req`/`fifo_empty` inputs, so a refresh is never issued in the middle of a granted transaction. Sits between the per-port FIFOs and the SDRAM command FSM, all in the `sdram_clk` domain.

---
 rtl/sdr_port_sched.sv | 164 ++++++++++++++++
 tb/tb_sdr_port_sched.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_port_sched.sv
// Round-robin port scheduler and auto-refresh timer in front of the SDR SDRAM
// command FSM; a refresh is only requested at an IDLE decision point.
module sdr_port_sched #(
    parameter int nr_of_ports = 4,
    parameter int rfr_length  = 390
) (
    input  logic                   sdram_clk,
    input  logic                   sdram_rst,
    input  logic [nr_of_ports-1:0] req_i,
    input  logic                   fsm_state_idle,
    input  logic                   fsm_cmd_aref,
    output logic [nr_of_ports-1:0] sel_o,
    output logic                   fifo_empty_o,
    output logic                   refresh_req_o,
    output logic                   rfr_miss_o
);

    localparam int          IW         = $clog2(nr_of_ports);
    localparam logic [15:0] RFR_RELOAD = 16'(rfr_length - 1);
    localparam logic [IW:0] NP         = (IW + 1)'(nr_of_ports);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_GRANT,
        ST_BUSY,
        ST_RFR,
        ST_RFRW
    } state_t;

    state_t                 state_q, state_d;
    logic [nr_of_ports-1:0] sel_q, sel_d, win_oh;
    logic [IW-1:0]          last_q, last_d, win_idx, sel_idx;
    logic [IW:0]            pos;
    logic [15:0]            cnt_q, cnt_d;
    logic                   rfr_pend_q, rfr_pend_d;
    logic                   rfr_miss_q, rfr_miss_d;
    logic                   refresh_req_q, refresh_req_d;
    logic                   expire, pend_clr;

    // Walk offsets from farthest to nearest so the port right after last wins.
    always_comb begin
        win_idx = '0;
        pos     = '0;
        for (int k = nr_of_ports; k >= 1; k--) begin
            pos = {1'b0, last_q} + (IW + 1)'(k);
            if (pos >= NP) begin
                pos = pos - NP;
            end
            if (req_i[pos[IW-1:0]]) begin
                win_idx = pos[IW-1:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < nr_of_ports; gi++) begin : g_win_oh
            assign win_oh[gi] = (win_idx == IW'(gi));
        end
    endgenerate

    always_comb begin
        sel_idx = '0;
        for (int j = 0; j < nr_of_ports; j++) begin
            if (sel_q[j]) begin
                sel_idx = IW'(j);
            end
        end
    end

    // An expiry that coincides with the ack keeps the new request pending.
    always_comb begin
        expire     = (cnt_q == 16'd0);
        cnt_d      = expire ? RFR_RELOAD : cnt_q - 16'd1;
        pend_clr   = (state_q == ST_RFR) && fsm_cmd_aref;
        rfr_pend_d = rfr_pend_q;
        rfr_miss_d = rfr_miss_q;
        if (expire) begin
            rfr_pend_d = 1'b1;
            if (rfr_pend_q && !pend_clr) begin
                rfr_miss_d = 1'b1;
            end
        end else if (pend_clr) begin
            rfr_pend_d = 1'b0;
        end
    end

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        last_d        = last_q;
        refresh_req_d = refresh_req_q;
        case (state_q)
            ST_INIT: begin
                if (fsm_state_idle) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (rfr_pend_q) begin
                    state_d       = ST_RFR;
                    refresh_req_d = 1'b1;
                end else if (|req_i) begin
                    state_d = ST_GRANT;
                    sel_d   = win_oh;
                end
            end
            ST_GRANT: begin
                if (!fsm_state_idle) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (fsm_state_idle) begin
                    state_d = ST_IDLE;
                    last_d  = sel_idx;
                    sel_d   = '0;
                end
            end
            ST_RFR: begin
                if (fsm_cmd_aref) begin
                    state_d       = ST_RFRW;
                    refresh_req_d = 1'b0;
                end
            end
            ST_RFRW: begin
                if (fsm_state_idle) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d       = ST_INIT;
                sel_d         = '0;
                refresh_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            state_q       <= ST_INIT;
            sel_q         <= '0;
            last_q        <= IW'(nr_of_ports - 1);
            cnt_q         <= RFR_RELOAD;
            rfr_pend_q    <= 1'b0;
            rfr_miss_q    <= 1'b0;
            refresh_req_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            rfr_pend_q    <= rfr_pend_d;
            rfr_miss_q    <= rfr_miss_d;
            refresh_req_q <= refresh_req_d;
        end
    end

    assign sel_o         = sel_q;
    assign fifo_empty_o  = ~|(req_i & sel_q);
    assign refresh_req_o = refresh_req_q;
    assign rfr_miss_o    = rfr_miss_q;

endmodule

// File: tb/tb_sdr_port_sched.sv
// Self-checking bench for sdr_port_sched: behavioural scheduler model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_sdr_port_sched;

    localparam int N = 4;
    localparam int L = 16;

    localparam int P_INIT  = 0;
    localparam int P_IDLE  = 1;
    localparam int P_GRANT = 2;
    localparam int P_BUSY  = 3;
    localparam int P_RFR   = 4;
    localparam int P_RFRW  = 5;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [3:0] req  = 4'b0000;
    logic       idle = 1'b0;
    logic       aref = 1'b0;
    logic [3:0] sel;
    logic       fe, rr, miss;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sdr_port_sched #(
        .nr_of_ports(N),
        .rfr_length (L)
    ) dut (
        .sdram_clk     (clk),
        .sdram_rst     (rst),
        .req_i         (req),
        .fsm_state_idle(idle),
        .fsm_cmd_aref  (aref),
        .sel_o         (sel),
        .fifo_empty_o  (fe),
        .refresh_req_o (rr),
        .rfr_miss_o    (miss)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edge counter for the timer, phase number, port search by offset.
    int         m_ph   = P_INIT;
    int         m_last = N - 1;
    int         m_n    = 0;
    logic [3:0] m_sel  = 4'b0000;
    bit         m_pend = 1'b0;
    bit         m_miss = 1'b0;
    bit         mx_exp, mx_clr, mx_old_pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph = P_INIT; m_last = N - 1; m_n = 0; m_sel = 4'b0000; m_pend = 1'b0; m_miss = 1'b0;
        end else begin
            m_n++;
            mx_exp      = (m_n % L) == 0;
            mx_clr      = (m_ph == P_RFR) && aref;
            mx_old_pend = m_pend;
            case (m_ph)
                P_INIT:  if (idle) m_ph = P_IDLE;
                P_IDLE: begin
                    if (mx_old_pend) begin
                        m_ph = P_RFR;
                    end else if (req != 4'b0000) begin
                        for (int k = 1; k <= N; k++) begin
                            if (req[(m_last + k) % N] && m_sel == 4'b0000) m_sel = 4'(1 << ((m_last + k) % N));
                        end
                        m_ph = P_GRANT;
                    end
                end
                P_GRANT: if (!idle) m_ph = P_BUSY;
                P_BUSY: begin
                    if (idle) begin
                        for (int p = 0; p < N; p++) if (m_sel[p]) m_last = p;
                        m_sel = 4'b0000;
                        m_ph  = P_IDLE;
                    end
                end
                P_RFR:   if (aref) m_ph = P_RFRW;
                P_RFRW:  if (idle) m_ph = P_IDLE;
                default: m_ph = P_INIT;
            endcase
            if (mx_exp) begin
                if (m_pend && !mx_clr) m_miss = 1'b1;
                m_pend = 1'b1;
            end else if (mx_clr) begin
                m_pend = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("model_sel", 32'(sel), 32'(m_sel));
        check("model_refresh_req", 32'(rr), 32'(m_ph == P_RFR));
        check("model_rfr_miss", 32'(miss), 32'(m_miss));
        check("model_fifo_empty", 32'(fe), 32'(~|(req & m_sel)));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000; idle = 1'b0; aref = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Plays the SDRAM FSM: serves one refresh or one transaction of busy_len cycles.
    task automatic serve(output logic [3:0] g, output bit was_rfr, input int busy_len);
        int t;
        g = 4'b0000; was_rfr = 1'b0; idle = 1'b1; aref = 1'b0; t = 0;
        while (sel == 4'b0000 && !rr && t < 60) begin
            tick();
            t++;
        end
        if (t >= 60) begin
            n_checks++; n_fail++;
            $display("FAIL serve_timeout: got no grant or refresh within %0d cycles", t);
        end else if (rr) begin
            was_rfr = 1'b1;
            aref = 1'b1;
            tick();
            aref = 1'b0;
            tick();
        end else begin
            g = sel;
            idle = 1'b0;
            repeat (busy_len) tick();
            idle = 1'b1;
            tick();
        end
    endtask

    logic [3:0] g_v;
    bit         r_v;
    int         got;
    bit         prev_rr;
    int         rises[$];
    logic [3:0] exp_all [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_alt [4] = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, with requests already present.
        req = 4'b1111;
        tick();
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_fifo_empty", 32'(fe), 32'h1);
        check("rst_refresh_req", 32'(rr), 32'h0);
        check("rst_rfr_miss", 32'(miss), 32'h0);

        // INIT ignores aref pulses; two expiries with no clear give a miss.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 40; i++) begin
            aref = (i == 10 || i == 25);
            tick();
        end
        aref = 1'b0;
        check("init_sel", 32'(sel), 32'h0);
        check("init_refresh_req", 32'(rr), 32'h0);
        check("init_rfr_miss", 32'(miss), 32'h1);
        serve(g_v, r_v, 6);
        check("init_first_is_rfr", 32'(r_v), 32'h1);
        serve(g_v, r_v, 6);
        check("init_first_grant", 32'(g_v), 32'h1);

        // Round robin over all ports, then over ports 0 and 2.
        do_reset();
        req = 4'b1111;
        got = 0;
        for (int it = 0; it < 20 && got < 5; it++) begin
            serve(g_v, r_v, 6);
            if (!r_v) begin
                check($sformatf("rr_all_%0d", got), 32'(g_v), 32'(exp_all[got]));
                got++;
            end
        end
        check("rr_all_count", got, 5);
        req = 4'b0101;
        got = 0;
        for (int it = 0; it < 20 && got < 4; it++) begin
            serve(g_v, r_v, 6);
            if (!r_v) begin
                check($sformatf("rr_alt_%0d", got), 32'(g_v), 32'(exp_alt[got]));
                got++;
            end
        end
        check("rr_alt_count", got, 4);

        // Periodic refresh with a prompt ack.
        do_reset();
        idle = 1'b1;
        prev_rr = 1'b0;
        rises.delete();
        for (int c = 0; c < 100; c++) begin
            if (rr && !prev_rr) rises.push_back(c);
            aref = rr;
            prev_rr = rr;
            tick();
        end
        aref = 1'b0;
        check("rfr_pulse_count", rises.size(), 6);
        if (rises.size() > 0) check("rfr_first_rise", rises[0], 17);
        for (int i = 1; i < rises.size(); i++) check($sformatf("rfr_interval_%0d", i), rises[i] - rises[i-1], L);
        check("rfr_no_miss", 32'(miss), 32'h0);

        // Expiry during BUSY is deferred to the next IDLE decision.
        do_reset();
        req = 4'b1111; idle = 1'b1;
        tick();
        tick();
        check("busy_grant", 32'(sel), 32'h1);
        idle = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("busy_no_rfr", 32'(rr), 32'h0);
        end
        idle = 1'b1;
        tick();
        check("busy_exit_sel", 32'(sel), 32'h0);
        tick();
        check("busy_then_rfr", 32'(rr), 32'h1);
        serve(g_v, r_v, 6);
        check("busy_rfr_served", 32'(r_v), 32'h1);
        serve(g_v, r_v, 6);
        check("busy_resume_port1", 32'(g_v), 32'h2);

        // Missed refresh is sticky through a later ack.
        do_reset();
        idle = 1'b1;
        repeat (2 * L + 4) tick();
        check("miss_set", 32'(miss), 32'h1);
        serve(g_v, r_v, 6);
        repeat (3) tick();
        check("miss_sticky", 32'(miss), 32'h1);

        // Granted request drops mid-transaction.
        do_reset();
        req = 4'b1111; idle = 1'b1;
        tick();
        tick();
        idle = 1'b0;
        tick();
        req = 4'b1110;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("drop_fifo_empty", 32'(fe), 32'h1);
            check("drop_sel_held", 32'(sel), 32'h1);
            tick();
        end
        idle = 1'b1;
        tick();
        check("drop_sel_cleared", 32'(sel), 32'h0);

        // Asynchronous reset in the middle of a grant and of a refresh request.
        do_reset();
        req = 4'b1111; idle = 1'b1;
        tick();
        tick();
        check("arst_pre_sel", 32'(sel), 32'h1);
        rst = 1'b1;
        #1;
        check("arst_sel", 32'(sel), 32'h0);
        check("arst_fifo_empty", 32'(fe), 32'h1);
        do_reset();
        idle = 1'b1;
        repeat (17) tick();
        check("arst_pre_rr", 32'(rr), 32'h1);
        rst = 1'b1;
        #1;
        check("arst_rr", 32'(rr), 32'h0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req  = 4'($urandom);
            idle = ($urandom_range(0, 3) != 0);
            aref = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            tick();
            rst = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
